gpio_input_conditioner: RTL and testbench

Conditions the raw GPIO input pins before they reach the gpio block's input register. It synchronises and debounces each pin, and the debounced levels drive `gpio.INPUT_PINS`. It also detects rising and falling edges per pin, latches them as pending flags and raises a level interrupt. Pending flags and enables are exposed through its own slot on the peripheral register bus, which uses the same ADDRESS/DATA_IN/DATA_OUT/WR protocol as gpio.

---
 rtl/gpio_cond_pkg.sv | 16 +
 rtl/debounce_cell.sv | 62 ++++++
 rtl/gpio_input_conditioner.sv | 100 ++++++++++
 tb/tb_gpio_input_conditioner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// Purpose: shared register map and defaults for the GPIO input conditioner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_cond_pkg;

  // Local register map on the peripheral bus slot
  localparam logic [7:0] GC_STATE   = 8'h00;
  localparam logic [7:0] GC_RISE_EN = 8'h01;
  localparam logic [7:0] GC_FALL_EN = 8'h02;
  localparam logic [7:0] GC_PENDING = 8'h03;
  localparam logic [7:0] GC_RAW     = 8'h04;

  // 1 ms at 12 MHz
  localparam int GC_DEBOUNCE_DEFAULT = 12000;

endpackage

// File: rtl/debounce_cell.sv
// Purpose: per-pin 2-flop synchroniser plus debounce counter with rise/fall accept pulses.
// Latency: clean follows a sustained change DEBOUNCE_CYCLES+2 edges after the first s1 sample.
// Backpressure: none; free-running, one pin per instance.
//
// Ports: CLK/RSTb (sync active-low), raw (async pad), clean (debounced level),
//        sync (synchronised s2 level), rise/fall (pulses high in the cycle whose
//        closing edge accepts the new level, so consumers register on that edge).
module debounce_cell
  import gpio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GC_DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic raw,
  output logic clean,
  output logic sync,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             accept;

  assign mismatch = (s2 != stable);
  // Accept happens on the edge that would otherwise take cnt past CNT_MAX,
  // so cnt never wraps.
  assign accept   = mismatch && (cnt == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign clean = stable;
  assign sync  = s2;
  assign rise  = accept && s2;
  assign fall  = accept && !s2;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Purpose: synchronise/debounce GPIO pads, latch enabled edges as pending flags, level IRQ.
// Latency: CLEAN_PINS/PENDING/IRQ update DEBOUNCE_CYCLES+2 edges after the first s1 sample; reads are combinational.
// Backpressure: none; bus accepts one write per cycle WR is high.
//
// Ports: CLK, RSTb (sync active-low), ADDRESS/DATA_IN/DATA_OUT/WR register bus,
//        RAW_PINS (async pads), CLEAN_PINS (to gpio.INPUT_PINS), IRQ (= |PENDING).
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int ADDRESS_BITS    = 8,
  parameter int CLK_FREQ        = 12000000,
  parameter int N_PINS          = 6,
  parameter int DEBOUNCE_CYCLES = GC_DEBOUNCE_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] ADDRESS,
  input  logic [BITS-1:0]         DATA_IN,
  output logic [BITS-1:0]         DATA_OUT,
  input  logic                    WR,
  input  logic [N_PINS-1:0]       RAW_PINS,
  output logic [N_PINS-1:0]       CLEAN_PINS,
  output logic                    IRQ
);

  logic [N_PINS-1:0] stable_v;
  logic [N_PINS-1:0] sync_v;
  logic [N_PINS-1:0] rise_v;
  logic [N_PINS-1:0] fall_v;

  logic [N_PINS-1:0] rise_en;
  logic [N_PINS-1:0] fall_en;
  logic [N_PINS-1:0] pending;
  logic [N_PINS-1:0] clr_mask;
  logic [N_PINS-1:0] set_mask;
  logic [N_PINS-1:0] wr_dat;
  logic              wr_rise_en;
  logic              wr_fall_en;
  logic              wr_pending;

  // DATA_IN bits above the pin field and the clock frequency have no effect on logic.
  logic unused_ok;
  assign unused_ok = ^{DATA_IN[BITS-1:N_PINS], (CLK_FREQ != 0)};

  genvar g;
  generate
    for (g = 0; g < N_PINS; g++) begin : g_pin
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .CLK  (CLK),
        .RSTb (RSTb),
        .raw  (RAW_PINS[g]),
        .clean(stable_v[g]),
        .sync (sync_v[g]),
        .rise (rise_v[g]),
        .fall (fall_v[g])
      );
    end
  endgenerate

  assign wr_dat     = DATA_IN[N_PINS-1:0];
  assign wr_rise_en = WR && (ADDRESS == ADDRESS_BITS'(GC_RISE_EN));
  assign wr_fall_en = WR && (ADDRESS == ADDRESS_BITS'(GC_FALL_EN));
  assign wr_pending = WR && (ADDRESS == ADDRESS_BITS'(GC_PENDING));

  // Events are gated by the enables as they stand before this edge's write;
  // set is OR'd after clear so a coincident set always survives.
  assign clr_mask = wr_pending ? wr_dat : '0;
  assign set_mask = (rise_v & rise_en) | (fall_v & fall_en);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
    end else begin
      if (wr_rise_en) rise_en <= wr_dat;
      if (wr_fall_en) fall_en <= wr_dat;
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      ADDRESS_BITS'(GC_STATE):   DATA_OUT[N_PINS-1:0] = stable_v;
      ADDRESS_BITS'(GC_RISE_EN): DATA_OUT[N_PINS-1:0] = rise_en;
      ADDRESS_BITS'(GC_FALL_EN): DATA_OUT[N_PINS-1:0] = fall_en;
      ADDRESS_BITS'(GC_PENDING): DATA_OUT[N_PINS-1:0] = pending;
      ADDRESS_BITS'(GC_RAW):     DATA_OUT[N_PINS-1:0] = sync_v;
      default:                   DATA_OUT = '0;
    endcase
  end

  assign CLEAN_PINS = stable_v;
  assign IRQ        = |pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
module tb_gpio_input_conditioner;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic [7:0]  ADDRESS;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        WR;
  logic [5:0]  RAW_PINS;
  logic [5:0]  CLEAN_PINS;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(
    .BITS(16), .ADDRESS_BITS(8), .CLK_FREQ(12000000), .N_PINS(6), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .WR(WR), .RAW_PINS(RAW_PINS), .CLEAN_PINS(CLEAN_PINS), .IRQ(IRQ)
  );

  always #10 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    ADDRESS = addr;
    #1;
    check(tag, DATA_OUT, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] dat);
    ADDRESS = addr;
    DATA_IN = dat;
    WR      = 1'b1;
    tick();
    WR      = 1'b0;
    DATA_IN = 16'h0000;
  endtask

  initial begin
    RSTb = 1'b0; ADDRESS = 8'h00; DATA_IN = 16'h0000; WR = 1'b0; RAW_PINS = 6'h3F;

    // Reset with all pads high
    repeat (3) tick();
    check("rst_clean", {10'd0, CLEAN_PINS}, 16'h0000);
    check("rst_irq", {15'd0, IRQ}, 16'h0000);
    chk_rd("rst_state", 8'h00, 16'h0000);
    chk_rd("rst_rise_en", 8'h01, 16'h0000);
    chk_rd("rst_fall_en", 8'h02, 16'h0000);
    chk_rd("rst_pending", 8'h03, 16'h0000);
    chk_rd("rst_raw", 8'h04, 16'h0000);
    RSTb = 1'b1;
    repeat (5) tick();
    check("rel_clean_e5", {10'd0, CLEAN_PINS}, 16'h0000);
    tick();
    check("rel_clean_e6", {10'd0, CLEAN_PINS}, 16'h003F);
    chk_rd("rel_pending", 8'h03, 16'h0000);
    check("rel_irq", {15'd0, IRQ}, 16'h0000);
    RAW_PINS = 6'h00;
    repeat (8) tick();
    check("settle_low", {10'd0, CLEAN_PINS}, 16'h0000);

    // Glitch rejection: pin0 high for 3 cycles
    wr(8'h01, 16'h0001);
    RAW_PINS = 6'h01;
    tick();
    tick();
    chk_rd("glitch_raw", 8'h04, 16'h0001);
    tick();
    RAW_PINS = 6'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_clean", {10'd0, CLEAN_PINS}, 16'h0000);
      check("glitch_irq", {15'd0, IRQ}, 16'h0000);
    end

    // Rise accept on pin0
    RAW_PINS = 6'h01;
    repeat (5) tick();
    check("rise_clean_e5", {10'd0, CLEAN_PINS}, 16'h0000);
    check("rise_irq_e5", {15'd0, IRQ}, 16'h0000);
    tick();
    chk_rd("rise_state", 8'h00, 16'h0001);
    chk_rd("rise_pending", 8'h03, 16'h0001);
    check("rise_irq", {15'd0, IRQ}, 16'h0001);
    wr(8'h03, 16'h0001);
    check("w1c_irq", {15'd0, IRQ}, 16'h0000);
    chk_rd("w1c_pending", 8'h03, 16'h0000);

    // Pin2 rise then fall, rise-only enable
    wr(8'h01, 16'h0004);
    RAW_PINS = 6'h05;
    repeat (6) tick();
    chk_rd("p2_rise_pending", 8'h03, 16'h0004);
    chk_rd("p2_rise_state", 8'h00, 16'h0005);
    RAW_PINS = 6'h01;
    repeat (5) tick();
    chk_rd("p2_fall_state_e5", 8'h00, 16'h0005);
    tick();
    chk_rd("p2_fall_state", 8'h00, 16'h0001);
    chk_rd("p2_fall_pending", 8'h03, 16'h0004);

    // Set/clear collision on pin1
    wr(8'h03, 16'h0004);
    chk_rd("coll_pre_pending", 8'h03, 16'h0000);
    wr(8'h01, 16'h0002);
    RAW_PINS = 6'h03;
    repeat (5) tick();
    check("coll_irq_pre", {15'd0, IRQ}, 16'h0000);
    wr(8'h03, 16'h0002);
    chk_rd("coll_pending", 8'h03, 16'h0002);
    check("coll_irq", {15'd0, IRQ}, 16'h0001);
    chk_rd("coll_state", 8'h00, 16'h0003);
    tick();
    check("coll_irq_hold", {15'd0, IRQ}, 16'h0001);

    // Decode
    wr(8'h01, 16'hFFFF);
    chk_rd("dec_rise_en", 8'h01, 16'h003F);
    chk_rd("dec_unmapped", 8'h07, 16'h0000);
    wr(8'h07, 16'hFFFF);
    chk_rd("dec_unmapped_wr", 8'h07, 16'h0000);
    chk_rd("dec_rise_en_keep", 8'h01, 16'h003F);
    wr(8'h03, 16'h0000);
    chk_rd("dec_w0_pending", 8'h03, 16'h0002);

    // Fall event with fall enable on pin0
    wr(8'h02, 16'h0001);
    chk_rd("fall_en_rd", 8'h02, 16'h0001);
    RAW_PINS = 6'h02;
    repeat (5) tick();
    chk_rd("fall_pending_e5", 8'h03, 16'h0002);
    tick();
    chk_rd("fall_pending", 8'h03, 16'h0003);
    chk_rd("fall_state", 8'h00, 16'h0002);
    check("fall_irq", {15'd0, IRQ}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
